alu_issue_queue: RTL

Buffered operation-issue stage that sits directly upstream of the 32-bit ALU top level. It accepts operations (A, B, Cin, 5-bit select) through a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the head entry to the combinational ALU and registers the ALU's F and 4-bit status into an output stage with its own valid/ready handshake. This decouples the ALU from producers and consumers that stall.

---
 rtl/alu_issue_queue.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Buffered issue stage in front of a combinational 32-bit ALU.
//               Operations {A, B, Cin, select[, use_c]} are accepted through
//               a valid/ready handshake into a DEPTH-entry FIFO. The head entry
//               drives the ALU combinationally. The ALU result and status are
//               captured into an output register with its own valid/ready
//               handshake.
// Optional    : `define ALU_CARRY_CHAIN_EN adds a carry register. The register
//               is loaded from alu_status[2] on every issue. A head entry with
//               use_c = 1 then takes its Cin from that register.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_*               - producer handshake and operation fields
//               alu_*              - to/from the combinational ALU
//               out_*              - registered result handshake
//               count              - entries in the FIFO (output reg excluded)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_cin,
    input  logic [4:0]                 in_sel,
    input  logic                       in_use_c,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic                       alu_cin,
    output logic [4:0]                 alu_sel,
    input  logic [WIDTH-1:0]           alu_f,
    input  logic [3:0]                 alu_status,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_f,
    output logic [3:0]                 out_status,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Storage (data only, no reset needed: validity is tracked by count)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   mem_a_q   [DEPTH];
    logic [WIDTH-1:0]   mem_b_q   [DEPTH];
    logic               mem_cin_q [DEPTH];
    logic [4:0]         mem_sel_q [DEPTH];
`ifdef ALU_CARRY_CHAIN_EN
    logic               mem_use_c_q [DEPTH];
    logic               carry_q;
`else
    // use_c has no meaning without the carry register.
    logic               w_unused_use_c;
    assign w_unused_use_c = in_use_c;
`endif

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_f_q,  out_f_d;
    logic [3:0]         out_status_q, out_status_d;

    logic w_empty;
    logic w_push;
    logic w_issue;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_empty  = (count_q == '0);
    // in_ready looks only at count, so a pop in a full cycle does not
    // open a slot until the following cycle.
    assign in_ready = (count_q != c_FULL_COUNT) && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_issue  = !w_empty && (!out_valid_q || out_ready);

    // ------------------------------------------------------------------
    // FIFO write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_a_q[wr_ptr_q]   <= in_a;
            mem_b_q[wr_ptr_q]   <= in_b;
            mem_cin_q[wr_ptr_q] <= in_cin;
            mem_sel_q[wr_ptr_q] <= in_sel;
`ifdef ALU_CARRY_CHAIN_EN
            mem_use_c_q[wr_ptr_q] <= in_use_c;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Head entry to the ALU; forced to zero when the queue is empty
    // ------------------------------------------------------------------
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_sel = '0;
        if (!w_empty) begin
            alu_a   = mem_a_q[rd_ptr_q];
            alu_b   = mem_b_q[rd_ptr_q];
            alu_sel = mem_sel_q[rd_ptr_q];
`ifdef ALU_CARRY_CHAIN_EN
            alu_cin = mem_use_c_q[rd_ptr_q] ? carry_q : mem_cin_q[rd_ptr_q];
`else
            alu_cin = mem_cin_q[rd_ptr_q];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_f_d      = out_f_q;
        out_status_d = out_status_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_issue) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_push, w_issue})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (w_issue) begin
            out_valid_d  = 1'b1;
            out_f_d      = alu_f;
            out_status_d = alu_status;
        end else if (out_valid_q && out_ready) begin
            // Drain: data held, only the valid flag drops.
            out_valid_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_f_q      <= '0;
            out_status_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_f_q      <= out_f_d;
            out_status_q <= out_status_d;
        end
    end

`ifdef ALU_CARRY_CHAIN_EN
    // Updated on the same edge that pops an op, so the next head sees the
    // carry-out of its predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (w_issue) begin
            carry_q <= alu_status[2];
        end
    end
`endif

    assign out_valid  = out_valid_q;
    assign out_f      = out_f_q;
    assign out_status = out_status_q;
    assign count      = count_q;

endmodule
`default_nettype wire
